ntt_coeff_loader: RTL

//   Upstream feeder for ntt_core. Accepts a valid/ready stream of 30-bit coefficients for one core.

---
 rtl/ntt_coeff_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ntt_coeff_loader.sv
// ntt_coeff_loader: packs a valid/ready stream of coefficients into pairs and fills an
// ntt_core's upper then lower memory in one frame, flagging coefficients not below MODULUS.
module ntt_coeff_loader #(
    parameter int unsigned     COEFF_WIDTH = 30,
    parameter int unsigned     ADDR_WIDTH  = 9,
    parameter int unsigned     DEPTH       = 512,
    parameter longint unsigned MODULUS     = 64'd1068564481
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [COEFF_WIDTH-1:0]     in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       upper_write_enable,
    output logic [ADDR_WIDTH-1:0]      upper_write_address,
    output logic [2*COEFF_WIDTH-1:0]   upper_data_input,
    output logic                       lower_write_enable,
    output logic [ADDR_WIDTH-1:0]      lower_write_address,
    output logic [2*COEFF_WIDTH-1:0]   lower_data_input,
    output logic                       busy,
    output logic                       done,
    output logic                       range_err
);

    localparam int unsigned KW = ADDR_WIDTH + 2;
    localparam logic [KW-1:0]         LAST_K  = KW'(4 * DEPTH - 1);
    localparam logic [KW-1:0]         HALF_K  = KW'(2 * DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [KW-1:0]            r_k;
    logic [COEFF_WIDTH-1:0]   r_held;

    logic                     w_handshake;
    logic                     w_lower;
    logic                     w_out_of_range;
    logic [ADDR_WIDTH-1:0]    w_pair;
    logic [ADDR_WIDTH-1:0]    w_addr;
    logic [2*COEFF_WIDTH-1:0] w_word;

    // Lower-half pair indices lie in [DEPTH, 2*DEPTH); subtracting DEPTH modulo 2**ADDR_WIDTH
    // yields the word address even when the pair index overflows ADDR_WIDTH bits.
    always_comb begin
        w_handshake    = (r_state == S_LOAD) && in_valid && in_ready;
        w_lower        = (r_k >= HALF_K);
        w_pair         = r_k[ADDR_WIDTH:1];
        w_addr         = w_lower ? (w_pair - DEPTH_A) : w_pair;
        w_word         = {in_data, r_held};
        w_out_of_range = (64'(in_data) >= MODULUS);
    end

    // NOTE: every register here is state, so all updates use non-blocking assignments;
    // blocking ones would let later statements observe half-updated values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= S_IDLE;
            r_k                 <= '0;
            r_held              <= '0;
            in_ready            <= 1'b0;
            upper_write_enable  <= 1'b0;
            upper_write_address <= '0;
            upper_data_input    <= '0;
            lower_write_enable  <= 1'b0;
            lower_write_address <= '0;
            lower_data_input    <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            range_err           <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle so every write is a single-cycle pulse;
            // address and data have no default and therefore hold between writes.
            upper_write_enable <= 1'b0;
            lower_write_enable <= 1'b0;
            done               <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LOAD;
                        r_k       <= '0;
                        range_err <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (w_handshake) begin
                        if (w_out_of_range) begin
                            range_err <= 1'b1;
                        end

                        if (!r_k[0]) begin
                            r_held <= in_data;
                        end else if (w_lower) begin
                            lower_write_enable  <= 1'b1;
                            lower_write_address <= w_addr;
                            lower_data_input    <= w_word;
                        end else begin
                            upper_write_enable  <= 1'b1;
                            upper_write_address <= w_addr;
                            upper_data_input    <= w_word;
                        end

                        if (r_k == LAST_K) begin
                            r_state  <= S_FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end

                S_FLUSH: begin
                    r_state <= S_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    a_one_half_at_a_time: assert property (
        @(posedge clk) disable iff (rst) !(upper_write_enable && lower_write_enable)
    );

    a_done_not_busy: assert property (
        @(posedge clk) disable iff (rst) !(done && busy)
    );

endmodule
